// File: rtl/warmboot_ctrl.sv
// Reboot sequencer for the iCE40 SB_WARMBOOT primitive: latches prioritised reboot
// requests, optionally drops the USB pull-up, then sets up S1/S0 and fires BOOT.
module warmboot_ctrl #(
    parameter int N_REQ     = 4,
    parameter bit DETACH_EN = 1'b1,
    parameter int DETACH_TW = 16,
    parameter int SETUP_LEN = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] req_sel,
    input  logic               inhibit,
    output logic               busy,
    output logic [2:0]         grant_id,
    output logic [N_REQ-1:0]   pending,
    output logic               usb_detach,
    output logic               wb_boot_o,
    output logic [1:0]         wb_sel_o
);

    localparam int TW = ((DETACH_TW > 4) ? DETACH_TW : 4) + 1;
    localparam logic [TW-1:0] DETACH_LAST = TW'((64'd1 << DETACH_TW) - 64'd1);
    localparam logic [TW-1:0] SETUP_LAST  = TW'(SETUP_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DETACH,
        S_SETUP,
        S_BOOT
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   pending_q, pending_d;
    logic [2*N_REQ-1:0] sel_q, sel_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [2:0]         grant_id_q, grant_id_d;
    logic [1:0]         wb_sel_q, wb_sel_d;
    logic               busy_q, busy_d;
    logic               usb_detach_q, usb_detach_d;
    logic               wb_boot_q, wb_boot_d;

    logic               win_found;
    logic [2:0]         win_idx;
    logic [1:0]         win_sel;

    // Lowest pending index wins; scanning downwards lets the last hit be the lowest.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        win_sel   = 2'b00;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                win_found = 1'b1;
                win_idx   = 3'(i);
                win_sel   = sel_q[2*i +: 2];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        sel_d      = sel_q;
        timer_d    = timer_q;
        grant_id_d = grant_id_q;
        wb_sel_d   = wb_sel_q;

        case (state_q)
            S_IDLE: begin
                if (!inhibit && win_found) begin
                    // Requests arriving in the grant cycle are intentionally dropped.
                    state_d    = DETACH_EN ? S_DETACH : S_SETUP;
                    grant_id_d = win_idx;
                    wb_sel_d   = win_sel;
                    pending_d  = '0;
                    timer_d    = '0;
                end else begin
                    for (int i = 0; i < N_REQ; i++) begin
                        if (req[i]) begin
                            pending_d[i]       = 1'b1;
                            sel_d[2*i +: 2]    = req_sel[2*i +: 2];
                        end
                    end
                end
            end
            S_DETACH: begin
                if (timer_q == DETACH_LAST) begin
                    timer_d = '0;
                    state_d = S_SETUP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_SETUP: begin
                if (timer_q == SETUP_LAST) begin
                    state_d = S_BOOT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_BOOT: begin
                // Terminal: only rst leaves this state.
                state_d = S_BOOT;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d       = (state_d != S_IDLE);
        usb_detach_d = DETACH_EN & (state_d != S_IDLE);
        wb_boot_d    = (state_d == S_BOOT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            sel_q        <= '0;
            timer_q      <= '0;
            grant_id_q   <= 3'd0;
            wb_sel_q     <= 2'b00;
            busy_q       <= 1'b0;
            usb_detach_q <= 1'b0;
            wb_boot_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            sel_q        <= sel_d;
            timer_q      <= timer_d;
            grant_id_q   <= grant_id_d;
            wb_sel_q     <= wb_sel_d;
            busy_q       <= busy_d;
            usb_detach_q <= usb_detach_d;
            wb_boot_q    <= wb_boot_d;
        end
    end

    assign busy       = busy_q;
    assign grant_id   = grant_id_q;
    assign pending    = pending_q;
    assign usb_detach = usb_detach_q;
    assign wb_boot_o  = wb_boot_q;
    assign wb_sel_o   = wb_sel_q;

`ifdef SYNTHESIS
    SB_WARMBOOT u_warmboot (
        .BOOT (wb_boot_q),
        .S1   (wb_sel_q[1]),
        .S0   (wb_sel_q[0])
    );
`endif

endmodule

// File: tb/tb_warmboot_ctrl.sv
// Directed + randomised bench for warmboot_ctrl: one instance with a short DETACH
// phase, one with DETACH disabled; outputs are compared as a packed snapshot.
module tb_warmboot_ctrl;

    logic       clk;
    logic       rst;

    logic [3:0] req_a, req_b;
    logic [7:0] req_sel_a, req_sel_b;
    logic       inhibit_a, inhibit_b;
    logic       busy_a, busy_b;
    logic [2:0] grant_id_a, grant_id_b;
    logic [3:0] pending_a, pending_b;
    logic       usb_detach_a, usb_detach_b;
    logic       wb_boot_a, wb_boot_b;
    logic [1:0] wb_sel_a, wb_sel_b;

    logic [11:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    warmboot_ctrl #(.N_REQ(4), .DETACH_EN(1'b1), .DETACH_TW(4), .SETUP_LEN(4)) u_dut_a (
        .clk(clk), .rst(rst), .req(req_a), .req_sel(req_sel_a), .inhibit(inhibit_a),
        .busy(busy_a), .grant_id(grant_id_a), .pending(pending_a),
        .usb_detach(usb_detach_a), .wb_boot_o(wb_boot_a), .wb_sel_o(wb_sel_a)
    );

    warmboot_ctrl #(.N_REQ(4), .DETACH_EN(1'b0), .DETACH_TW(4), .SETUP_LEN(2)) u_dut_b (
        .clk(clk), .rst(rst), .req(req_b), .req_sel(req_sel_b), .inhibit(inhibit_b),
        .busy(busy_b), .grant_id(grant_id_b), .pending(pending_b),
        .usb_detach(usb_detach_b), .wb_boot_o(wb_boot_b), .wb_sel_o(wb_sel_b)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [11:0] mk(input logic b, input logic [2:0] g, input logic [3:0] p,
                                       input logic d, input logic bt, input logic [1:0] s);
        return {b, g, p, d, bt, s};
    endfunction

    function automatic logic [11:0] obs_a();
        return {busy_a, grant_id_a, pending_a, usb_detach_a, wb_boot_a, wb_sel_a};
    endfunction

    function automatic logic [11:0] obs_b();
        return {busy_b, grant_id_b, pending_b, usb_detach_b, wb_boot_b, wb_sel_b};
    endfunction

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [11:0] e);
        exp_q.push_back(e);
    endtask

    // scoreboard: pop the oldest expectation and compare against the observed snapshot
    task automatic chk(input string tag, input logic [11:0] obs);
        logic [11:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %h, no expectation queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    // Asynchronous reset mid-cycle: outputs must clear without any clock edge.
    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        push(mk(0, 3'd0, 4'b0000, 0, 0, 2'b00));
        chk({tag, "_a"}, obs_a());
        push(mk(0, 3'd0, 4'b0000, 0, 0, 2'b00));
        chk({tag, "_b"}, obs_b());
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        logic [3:0] mask;
        logic [7:0] sels;
        logic [2:0] g;
        logic [1:0] gs;

        rst       = 1'b1;
        req_a     = '0;
        req_b     = '0;
        req_sel_a = '0;
        req_sel_b = '0;
        inhibit_a = 1'b0;
        inhibit_b = 1'b0;
        tick(3);
        push(mk(0, 3'd0, 4'b0000, 0, 0, 2'b00));
        chk("reset_a", obs_a());
        push(mk(0, 3'd0, 4'b0000, 0, 0, 2'b00));
        chk("reset_b", obs_b());
        rst = 1'b0;
        tick(2);

        // Priority: req[3] sel 10 and req[1] sel 11 together -> grant 1, sel 11
        req_a     = 4'b1010;
        req_sel_a = 8'b10_00_11_00;
        push(mk(0, 3'd0, 4'b1010, 0, 0, 2'b00));
        push(mk(1, 3'd1, 4'b0000, 1, 0, 2'b11));
        tick(1);
        req_a = '0;
        chk("prio_pending", obs_a());
        tick(1);
        chk("prio_grant", obs_a());
        tick(3);
        async_reset("rst_in_detach");

        // Basic grant: req[2] sel 01, full sequence to BOOT, late request ignored
        req_a     = 4'b0100;
        req_sel_a = 8'b00_01_00_00;
        push(mk(0, 3'd0, 4'b0100, 0, 0, 2'b00));
        push(mk(1, 3'd2, 4'b0000, 1, 0, 2'b01));
        tick(1);
        req_a = '0;
        chk("basic_pending", obs_a());
        tick(1);
        chk("basic_grant", obs_a());
        req_a     = 4'b0001;
        req_sel_a = 8'b00_00_00_11;
        inhibit_a = 1'b1;
        push(mk(1, 3'd2, 4'b0000, 1, 0, 2'b01));
        tick(1);
        req_a     = '0;
        inhibit_a = 1'b0;
        chk("late_req_detach", obs_a());
        push(mk(1, 3'd2, 4'b0000, 1, 0, 2'b01));
        tick(14);
        chk("detach_last", obs_a());
        push(mk(1, 3'd2, 4'b0000, 1, 0, 2'b01));
        tick(4);
        chk("setup_last", obs_a());
        push(mk(1, 3'd2, 4'b0000, 1, 1, 2'b01));
        tick(1);
        chk("boot_rise", obs_a());
        push(mk(1, 3'd2, 4'b0000, 1, 1, 2'b01));
        tick(100);
        chk("boot_held", obs_a());
        async_reset("rst_in_boot");

        // Inhibit: requests accumulate, grant follows release
        inhibit_a = 1'b1;
        req_a     = 4'b0001;
        req_sel_a = 8'b00_00_00_01;
        push(mk(0, 3'd0, 4'b0001, 0, 0, 2'b00));
        tick(1);
        req_a = '0;
        chk("inh_first", obs_a());
        tick(2);
        req_a     = 4'b0100;
        req_sel_a = 8'b00_10_00_00;
        push(mk(0, 3'd0, 4'b0101, 0, 0, 2'b00));
        push(mk(0, 3'd0, 4'b0101, 0, 0, 2'b00));
        tick(1);
        req_a = '0;
        chk("inh_second", obs_a());
        tick(5);
        chk("inh_hold", obs_a());
        inhibit_a = 1'b0;
        push(mk(1, 3'd0, 4'b0000, 1, 0, 2'b01));
        tick(1);
        chk("inh_release", obs_a());
        async_reset("rst_after_inh");

        // Overwrite: req[1] sel 01 then sel 10 before grant -> last wins
        inhibit_a = 1'b1;
        req_a     = 4'b0010;
        req_sel_a = 8'b00_00_01_00;
        tick(1);
        req_sel_a = 8'b00_00_10_00;
        push(mk(0, 3'd0, 4'b0010, 0, 0, 2'b00));
        push(mk(1, 3'd1, 4'b0000, 1, 0, 2'b10));
        tick(1);
        req_a = '0;
        chk("ovw_pending", obs_a());
        inhibit_a = 1'b0;
        tick(1);
        chk("ovw_grant", obs_a());
        async_reset("rst_after_ovw");

        // Request in the grant cycle is dropped
        req_a     = 4'b0010;
        req_sel_a = 8'b00_00_01_00;
        push(mk(0, 3'd0, 4'b0010, 0, 0, 2'b00));
        push(mk(1, 3'd1, 4'b0000, 1, 0, 2'b01));
        push(mk(1, 3'd1, 4'b0000, 1, 0, 2'b01));
        tick(1);
        req_a     = 4'b0001;
        req_sel_a = 8'b00_00_00_11;
        chk("gc_pending", obs_a());
        tick(1);
        req_a = '0;
        chk("gc_grant", obs_a());
        tick(1);
        chk("gc_dropped", obs_a());
        async_reset("rst_after_gc");

        // Random request masks: lowest set index is granted with its own select
        for (int r = 0; r < 6; r++) begin
            mask = 4'($urandom_range(1, 15));
            sels = 8'($urandom_range(0, 255));
            g    = 3'd0;
            gs   = 2'b00;
            for (int i = 3; i >= 0; i--) begin
                if (mask[i]) begin
                    g  = 3'(i);
                    gs = sels[2*i +: 2];
                end
            end
            req_a     = mask;
            req_sel_a = sels;
            push(mk(0, 3'd0, mask, 0, 0, 2'b00));
            push(mk(1, g, 4'b0000, 1, 0, gs));
            tick(1);
            req_a = '0;
            chk("rand_pending", obs_a());
            tick(1);
            chk("rand_grant", obs_a());
            async_reset("rand_rst");
        end

        // DETACH disabled, SETUP_LEN=2: busy at t+2 without detach, BOOT at t+4
        req_b     = 4'b0001;
        req_sel_b = 8'b00_00_00_10;
        push(mk(0, 3'd0, 4'b0001, 0, 0, 2'b00));
        push(mk(1, 3'd0, 4'b0000, 0, 0, 2'b10));
        push(mk(1, 3'd0, 4'b0000, 0, 0, 2'b10));
        push(mk(1, 3'd0, 4'b0000, 0, 1, 2'b10));
        tick(1);
        req_b = '0;
        chk("nodet_pending", obs_b());
        tick(1);
        chk("nodet_busy", obs_b());
        tick(1);
        chk("nodet_setup", obs_b());
        tick(1);
        chk("nodet_boot", obs_b());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/warmboot_ctrl.md
Name: warmboot_ctrl

Overview:
- Sequences the iCE40 SB_WARMBOOT primitive on behalf of several reboot requesters: button/DFU helper, USB DFU detach handler, CSR soft-reboot, watchdog.
- Latches each request with its image select and arbitrates by fixed priority.
- Optionally drops the USB pull-up for a fixed detach period so the host sees a disconnect.
- Sets up S0/S1 for a guaranteed number of cycles, then asserts BOOT permanently.
- Sits at the top level; it is the only instance of SB_WARMBOOT in the design.

Parameters:
- N_REQ, 4, number of requesters (1..8); index 0 has the highest priority.
- DETACH_EN, 1, 1 = run the DETACH phase before boot; 0 = skip DETACH.
- DETACH_TW, 16, DETACH phase lasts exactly 2^DETACH_TW cycles.
- SETUP_LEN, 4, cycles S0/S1 are held stable before BOOT rises (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester single-cycle reboot request pulse.
- req_sel  in  2*N_REQ  image select for requester i, on bits [2i+1:2i], sampled together with req[i].
- inhibit  in  1  holds off granting, e.g. during a flash erase/program.
- busy  out  1  high whenever state is not IDLE.
- grant_id  out  3  index of the granted requester; valid while busy.
- pending  out  N_REQ  latched, not-yet-granted requests.
- usb_detach  out  1  high = disconnect the USB pull-up.
- wb_boot_o  out  1  mirror of SB_WARMBOOT.BOOT.
- wb_sel_o  out  2  mirror of {S1,S0}.

Behaviour:
- Reset values (async, all outputs): state=IDLE, pending=0, grant_id=0, busy=0, usb_detach=0, wb_boot_o=0, wb_sel_o=00, timer=0. Reset asserted in any state, BOOT included, returns to IDLE immediately.
- Latching: at each edge in IDLE, for every i with req[i]=1, set pending[i]=1 and store sel_i <= req_sel[2i+1:2i].
  - A repeated req[i] while pending[i]=1 overwrites sel_i; last request wins.
- States: IDLE, DETACH, SETUP, BOOT.
- IDLE:
  - Grant condition: inhibit=0 and |pending.
  - On grant at the next edge: g = lowest set index; grant_id<=g; wb_sel_o<=sel_g; pending<=0; timer<=0.
  - Next state on grant: DETACH if DETACH_EN, else SETUP.
  - Requests arriving in the grant cycle are dropped.
  - Latency: req pulse at cycle t gives pending at t+1 and busy=1 at t+2 when inhibit=0.
  - While inhibit=1, requests keep accumulating in pending and no grant is made.
- DETACH:
  - usb_detach=1; timer increments every cycle.
  - When timer reaches 2^DETACH_TW-1: timer<=0, next state SETUP.
  - Total dwell is exactly 2^DETACH_TW cycles.
- SETUP:
  - wb_sel_o is stable; wb_boot_o=0; usb_detach=1 if DETACH_EN.
  - When timer reaches SETUP_LEN-1, next state BOOT. Dwell is exactly SETUP_LEN cycles.
- BOOT:
  - wb_boot_o=1 and is held until reset; the FPGA reconfigures.
  - wb_sel_o and usb_detach are held.
- Request handling outside IDLE:
  - Once busy, req and inhibit are ignored; pending stays 0.
  - The grant is irrevocable; there is no abort path except rst.
- Output timing:
  - wb_sel_o changes only on the IDLE->DETACH/SETUP transition, never while wb_boot_o=1.
  - All outputs are registered.
- Timer width: max(DETACH_TW, 4)+1 bits; no wrap-around occurs within any state.
- Single-cycle requests from all N_REQ requesters in the same cycle: all latch; the lowest index is granted.
- Internally instantiates SB_WARMBOOT with BOOT=wb_boot_o, S0=wb_sel_o[0], S1=wb_sel_o[1].

Test Plan:
- Basic grant: DETACH_TW=4, SETUP_LEN=4; req[2]=1 with sel 01 at cycle 10.
  - pending=0100 at 11; busy, usb_detach=1, grant_id=2, wb_sel_o=01 at 12.
  - SETUP at 28; wb_boot_o=1 at 32 and held for 100 cycles.
- Priority: req[3] (sel 10) and req[1] (sel 11) in the same cycle -> grant_id=1, wb_sel_o=11; the req[3] record is cleared.
- Inhibit: inhibit=1; req[0] sel 01 at cycle 5, req[2] sel 10 at cycle 8 -> no busy, pending=0101; inhibit drops at 20 -> busy at 21, grant_id=0, wb_sel_o=01.
- Late/overwrite requests: req[0] arriving in the grant cycle or during DETACH -> pending stays 0, wb_sel_o unchanged. Repeated req[1] with sel 01 then 10 before grant -> wb_sel_o=10.
- DETACH_EN=0, SETUP_LEN=2: req[0] at t -> busy at t+2 with usb_detach=0; wb_boot_o=1 at t+4.
- Reset mid-operation: assert rst during DETACH and again during BOOT -> all outputs return to reset values asynchronously; a new request after release completes a full sequence.
